wg_host_sequencer: RTL and testbench

Kernel-level workgroup source that sits directly upstream of the dispatcher. It latches one kernel descriptor, generates the per-workgroup host request stream (`host_*`) with a valid/ack handshake against the inflight WG buffer, and counts workgroup completions until the kernel is done. It provides synthesizable stimulus for the hardware dispatcher wrapper in place of a testbench-only host model.

---
 rtl/wg_host_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_wg_host_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wg_host_sequencer.sv
`timescale 1ns/1ps
// Kernel-level workgroup source: latches one descriptor, streams one host request
// per workgroup through a valid/ack handshake, and counts completions until done.
module wg_host_sequencer #(
   parameter int WG_ID_WIDTH     = 6,
   parameter int WF_COUNT_WIDTH  = 4,
   parameter int WAVE_ITEM_WIDTH = 6,
   parameter int VGPR_ID_WIDTH   = 8,
   parameter int SGPR_ID_WIDTH   = 4,
   parameter int LDS_ID_WIDTH    = 8,
   parameter int GDS_ID_WIDTH    = 14,
   parameter int MEM_ADDR_WIDTH  = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_start,
   input  logic [WG_ID_WIDTH:0]        cfg_num_wg,
   input  logic [WF_COUNT_WIDTH-1:0]   cfg_num_wf,
   input  logic [WAVE_ITEM_WIDTH-1:0]  cfg_wf_size,
   input  logic [VGPR_ID_WIDTH:0]      cfg_vgpr_size_per_wf,
   input  logic [SGPR_ID_WIDTH:0]      cfg_sgpr_size_per_wf,
   input  logic [LDS_ID_WIDTH:0]       cfg_lds_size_total,
   input  logic [GDS_ID_WIDTH:0]       cfg_gds_size_total,
   input  logic [MEM_ADDR_WIDTH-1:0]   cfg_start_pc,
   output logic                        host_wg_valid,
   output logic [WG_ID_WIDTH-1:0]      host_wg_id,
   output logic [WF_COUNT_WIDTH-1:0]   host_num_wf,
   output logic [WAVE_ITEM_WIDTH-1:0]  host_wf_size,
   output logic [VGPR_ID_WIDTH:0]      host_vgpr_size_per_wf,
   output logic [SGPR_ID_WIDTH:0]      host_sgpr_size_per_wf,
   output logic [LDS_ID_WIDTH:0]       host_lds_size_total,
   output logic [GDS_ID_WIDTH:0]       host_gds_size_total,
   output logic [MEM_ADDR_WIDTH-1:0]   host_start_pc,
   output logic [VGPR_ID_WIDTH:0]      host_vgpr_size_total,
   output logic [SGPR_ID_WIDTH:0]      host_sgpr_size_total,
   input  logic                        inflight_wg_buffer_host_rcvd_ack,
   input  logic                        inflight_wg_buffer_host_wf_done,
   input  logic [WG_ID_WIDTH-1:0]      inflight_wg_buffer_host_wf_done_wg_id,
   output logic                        busy,
   output logic                        kernel_done,
   output logic                        kernel_err
);

   localparam int NUM_SLOTS = 1 << WG_ID_WIDTH;
   localparam int VPROD_W   = WF_COUNT_WIDTH + VGPR_ID_WIDTH + 1;
   localparam int SPROD_W   = WF_COUNT_WIDTH + SGPR_ID_WIDTH + 1;
   localparam logic [WG_ID_WIDTH:0] CNT_ONE  = 1;
   localparam logic [WG_ID_WIDTH:0] CNT_ZERO = 0;

   typedef enum logic [1:0] {IDLE, ISSUE, GAP, DRAIN} state_e;

   state_e                        state_q;
   logic [WG_ID_WIDTH:0]          numWg_q;
   logic [WG_ID_WIDTH:0]          issueCnt_q, issueCnt_d;
   logic [WG_ID_WIDTH:0]          doneCnt_q, doneCnt_d;
   logic [NUM_SLOTS-1:0]          doneMap_q, doneMap_d;
   logic [WF_COUNT_WIDTH-1:0]     numWf_q;
   logic [WAVE_ITEM_WIDTH-1:0]    wfSize_q;
   logic [VGPR_ID_WIDTH:0]        vgprPerWf_q, vgprTotal_q;
   logic [SGPR_ID_WIDTH:0]        sgprPerWf_q, sgprTotal_q;
   logic [LDS_ID_WIDTH:0]         ldsTotal_q;
   logic [GDS_ID_WIDTH:0]         gdsTotal_q;
   logic [MEM_ADDR_WIDTH-1:0]     startPc_q;
   logic                          valid_q, kernelDone_q, kernelErr_q;

   logic [VPROD_W-1:0]            vgprProd;
   logic [SPROD_W-1:0]            sgprProd;
   logic                          cfgBad;
   logic                          doneLegal, doneIllegal, ackTaken;

   // Products are formed at full width so overflow is visible before truncation.
   always_comb begin
      vgprProd = VPROD_W'(cfg_num_wf) * VPROD_W'(cfg_vgpr_size_per_wf);
      sgprProd = SPROD_W'(cfg_num_wf) * SPROD_W'(cfg_sgpr_size_per_wf);
      cfgBad   = (cfg_num_wg == CNT_ZERO)
               || (|vgprProd[VPROD_W-1:VGPR_ID_WIDTH+1])
               || (|sgprProd[SPROD_W-1:SGPR_ID_WIDTH+1]);
   end

   // A completion is legal only for an already-issued WG not yet marked done;
   // the WG being acked this cycle is not yet below the issue count.
   always_comb begin
      doneLegal   = (state_q != IDLE) && inflight_wg_buffer_host_wf_done
                  && ({1'b0, inflight_wg_buffer_host_wf_done_wg_id} < issueCnt_q)
                  && !doneMap_q[inflight_wg_buffer_host_wf_done_wg_id];
      doneIllegal = (state_q != IDLE) && inflight_wg_buffer_host_wf_done && !doneLegal;
      doneMap_d   = doneMap_q;
      doneCnt_d   = doneCnt_q;
      if (doneLegal) begin
         doneMap_d[inflight_wg_buffer_host_wf_done_wg_id] = 1'b1;
         doneCnt_d = doneCnt_q + CNT_ONE;
      end
      ackTaken   = (state_q == ISSUE) && inflight_wg_buffer_host_rcvd_ack;
      issueCnt_d = ackTaken ? (issueCnt_q + CNT_ONE) : issueCnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         numWg_q      <= '0;
         issueCnt_q   <= '0;
         doneCnt_q    <= '0;
         doneMap_q    <= '0;
         numWf_q      <= '0;
         wfSize_q     <= '0;
         vgprPerWf_q  <= '0;
         vgprTotal_q  <= '0;
         sgprPerWf_q  <= '0;
         sgprTotal_q  <= '0;
         ldsTotal_q   <= '0;
         gdsTotal_q   <= '0;
         startPc_q    <= '0;
         valid_q      <= 1'b0;
         kernelDone_q <= 1'b0;
         kernelErr_q  <= 1'b0;
      end else begin
         kernelDone_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cfg_start) begin
                  if (cfgBad) begin
                     kernelErr_q <= 1'b1;
                  end else begin
                     kernelErr_q <= 1'b0;
                     numWg_q     <= cfg_num_wg;
                     numWf_q     <= cfg_num_wf;
                     wfSize_q    <= cfg_wf_size;
                     vgprPerWf_q <= cfg_vgpr_size_per_wf;
                     sgprPerWf_q <= cfg_sgpr_size_per_wf;
                     vgprTotal_q <= vgprProd[VGPR_ID_WIDTH:0];
                     sgprTotal_q <= sgprProd[SGPR_ID_WIDTH:0];
                     ldsTotal_q  <= cfg_lds_size_total;
                     gdsTotal_q  <= cfg_gds_size_total;
                     startPc_q   <= cfg_start_pc;
                     issueCnt_q  <= '0;
                     doneCnt_q   <= '0;
                     doneMap_q   <= '0;
                     valid_q     <= 1'b1;
                     state_q     <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (ackTaken) begin
                  valid_q <= 1'b0;
                  state_q <= (issueCnt_d == numWg_q) ? DRAIN : GAP;
               end
            end
            GAP: begin
               valid_q <= 1'b1;
               state_q <= ISSUE;
            end
            DRAIN: begin
               if (doneCnt_d == numWg_q) begin
                  kernelDone_q <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
         if (state_q != IDLE) begin
            issueCnt_q <= issueCnt_d;
            doneCnt_q  <= doneCnt_d;
            doneMap_q  <= doneMap_d;
            if (doneIllegal) kernelErr_q <= 1'b1;
         end
      end
   end

   assign host_wg_valid         = valid_q;
   assign host_wg_id            = issueCnt_q[WG_ID_WIDTH-1:0];
   assign host_num_wf           = numWf_q;
   assign host_wf_size          = wfSize_q;
   assign host_vgpr_size_per_wf = vgprPerWf_q;
   assign host_sgpr_size_per_wf = sgprPerWf_q;
   assign host_lds_size_total   = ldsTotal_q;
   assign host_gds_size_total   = gdsTotal_q;
   assign host_start_pc         = startPc_q;
   assign host_vgpr_size_total  = vgprTotal_q;
   assign host_sgpr_size_total  = sgprTotal_q;
   assign busy                  = (state_q != IDLE);
   assign kernel_done           = kernelDone_q;
   assign kernel_err            = kernelErr_q;

endmodule

// File: tb/tb_wg_host_sequencer.sv
`timescale 1ns/1ps
// Randomized bench for wg_host_sequencer: a transaction-level model of issued and
// completed workgroups predicts every handshake output cycle by cycle.
module tb_wg_host_sequencer;

   localparam int WGW = 6, WFW = 4, WIW = 6, VW = 8, SW = 4, LW = 8, GW = 14, MW = 32;
   localparam int VMAX = (1 << (VW + 1)) - 1;
   localparam int SMAX = (1 << (SW + 1)) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic            cfg_start;
   logic [WGW:0]    cfg_num_wg;
   logic [WFW-1:0]  cfg_num_wf;
   logic [WIW-1:0]  cfg_wf_size;
   logic [VW:0]     cfg_vgpr_size_per_wf;
   logic [SW:0]     cfg_sgpr_size_per_wf;
   logic [LW:0]     cfg_lds_size_total;
   logic [GW:0]     cfg_gds_size_total;
   logic [MW-1:0]   cfg_start_pc;
   logic            host_wg_valid;
   logic [WGW-1:0]  host_wg_id;
   logic [WFW-1:0]  host_num_wf;
   logic [WIW-1:0]  host_wf_size;
   logic [VW:0]     host_vgpr_size_per_wf, host_vgpr_size_total;
   logic [SW:0]     host_sgpr_size_per_wf, host_sgpr_size_total;
   logic [LW:0]     host_lds_size_total;
   logic [GW:0]     host_gds_size_total;
   logic [MW-1:0]   host_start_pc;
   logic            ack, wfDone;
   logic [WGW-1:0]  wfDoneId;
   logic            busy, kernel_done, kernel_err;

   wg_host_sequencer dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_wg(cfg_num_wg),
      .cfg_num_wf(cfg_num_wf), .cfg_wf_size(cfg_wf_size),
      .cfg_vgpr_size_per_wf(cfg_vgpr_size_per_wf), .cfg_sgpr_size_per_wf(cfg_sgpr_size_per_wf),
      .cfg_lds_size_total(cfg_lds_size_total), .cfg_gds_size_total(cfg_gds_size_total),
      .cfg_start_pc(cfg_start_pc), .host_wg_valid(host_wg_valid), .host_wg_id(host_wg_id),
      .host_num_wf(host_num_wf), .host_wf_size(host_wf_size),
      .host_vgpr_size_per_wf(host_vgpr_size_per_wf), .host_sgpr_size_per_wf(host_sgpr_size_per_wf),
      .host_lds_size_total(host_lds_size_total), .host_gds_size_total(host_gds_size_total),
      .host_start_pc(host_start_pc), .host_vgpr_size_total(host_vgpr_size_total),
      .host_sgpr_size_total(host_sgpr_size_total),
      .inflight_wg_buffer_host_rcvd_ack(ack), .inflight_wg_buffer_host_wf_done(wfDone),
      .inflight_wg_buffer_host_wf_done_wg_id(wfDoneId),
      .busy(busy), .kernel_done(kernel_done), .kernel_err(kernel_err)
   );

   int testsRun = 0;
   int testsFailed = 0;

   // Reference model: how many WGs are issued, which ones have completed.
   bit       mBusy, mValid, mErr, mKdone;
   int       mIssued, mDoneCnt, mNumWg, mNumWf, mWfSize, mVgpr, mSgpr, mLds, mGds;
   logic [MW-1:0] mPc;
   bit       mSeen[64];

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      mBusy = 0; mValid = 0; mErr = 0; mKdone = 0;
      mIssued = 0; mDoneCnt = 0; mNumWg = 0;
      foreach (mSeen[i]) mSeen[i] = 0;
   endtask

   task automatic modelEdge(input bit start, input bit ackIn, input bit done, input int doneId);
      int vp, sp;
      bit wasValid;
      mKdone = 0;
      if (!mBusy) begin
         if (start) begin
            vp = int'(cfg_num_wf) * int'(cfg_vgpr_size_per_wf);
            sp = int'(cfg_num_wf) * int'(cfg_sgpr_size_per_wf);
            if (cfg_num_wg == 0 || vp > VMAX || sp > SMAX) begin
               mErr = 1;
            end else begin
               mErr = 0; mBusy = 1; mValid = 1; mIssued = 0; mDoneCnt = 0;
               foreach (mSeen[i]) mSeen[i] = 0;
               mNumWg = int'(cfg_num_wg); mNumWf = int'(cfg_num_wf);
               mWfSize = int'(cfg_wf_size); mVgpr = int'(cfg_vgpr_size_per_wf);
               mSgpr = int'(cfg_sgpr_size_per_wf); mLds = int'(cfg_lds_size_total);
               mGds = int'(cfg_gds_size_total); mPc = cfg_start_pc;
            end
         end
      end else begin
         wasValid = mValid;
         if (done) begin
            if (doneId < mIssued && !mSeen[doneId]) begin
               mSeen[doneId] = 1;
               mDoneCnt++;
            end else begin
               mErr = 1;
            end
         end
         if (wasValid) begin
            if (ackIn) begin
               mIssued++;
               mValid = 0;
            end
         end else if (mIssued < mNumWg) begin
            mValid = 1;
         end else if (mDoneCnt == mNumWg) begin
            mKdone = 1;
            mBusy = 0;
         end
      end
   endtask

   task automatic checkAll();
      checkOutput("busy", busy, mBusy);
      checkOutput("valid", host_wg_valid, mValid);
      checkOutput("kernelDone", kernel_done, mKdone);
      checkOutput("kernelErr", kernel_err, mErr);
      if (mValid) begin
         checkOutput("wgId", host_wg_id, mIssued);
         checkOutput("numWf", host_num_wf, mNumWf);
         checkOutput("wfSize", host_wf_size, mWfSize);
         checkOutput("vgprPerWf", host_vgpr_size_per_wf, mVgpr);
         checkOutput("sgprPerWf", host_sgpr_size_per_wf, mSgpr);
         checkOutput("ldsTotal", host_lds_size_total, mLds);
         checkOutput("gdsTotal", host_gds_size_total, mGds);
         checkOutput("startPc", host_start_pc, mPc);
         checkOutput("vgprTotal", host_vgpr_size_total, mNumWf * mVgpr);
         checkOutput("sgprTotal", host_sgpr_size_total, mNumWf * mSgpr);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "Busy"}, busy, 0);
      checkOutput({tag, "Valid"}, host_wg_valid, 0);
      checkOutput({tag, "Done"}, kernel_done, 0);
      checkOutput({tag, "Err"}, kernel_err, 0);
      checkOutput({tag, "Id"}, host_wg_id, 0);
      checkOutput({tag, "Fields"}, {host_num_wf, host_wf_size, host_vgpr_size_per_wf,
                  host_sgpr_size_per_wf, host_lds_size_total, host_gds_size_total}, 0);
      checkOutput({tag, "Pc"}, host_start_pc, 0);
      checkOutput({tag, "Totals"}, {host_vgpr_size_total, host_sgpr_size_total}, 0);
   endtask

   // Drive one cycle of inputs, advance the clock, update the model, then compare.
   task automatic applyStimulus(input bit start, input bit ackIn, input bit done, input int doneId);
      cfg_start = start; ack = ackIn; wfDone = done; wfDoneId = WGW'(doneId);
      @(posedge clk);
      modelEdge(start, ackIn, done, doneId);
      #1;
      checkAll();
   endtask

   task automatic setCfg(input int numWg, input int numWf, input int vgpr, input int sgpr);
      cfg_num_wg = (WGW + 1)'(numWg);
      cfg_num_wf = WFW'(numWf);
      cfg_vgpr_size_per_wf = (VW + 1)'(vgpr);
      cfg_sgpr_size_per_wf = (SW + 1)'(sgpr);
      cfg_wf_size = WIW'($urandom);
      cfg_lds_size_total = (LW + 1)'($urandom);
      cfg_gds_size_total = (GW + 1)'($urandom);
      cfg_start_pc = $urandom;
   endtask

   task automatic setLegalCfg(input int numWg);
      int wf;
      wf = $urandom_range(0, 15);
      setCfg(numWg, wf, (wf == 0) ? $urandom_range(0, VMAX) : $urandom_range(0, VMAX / wf),
             (wf == 0) ? $urandom_range(0, SMAX) : $urandom_range(0, SMAX / wf));
   endtask

   task automatic runKernel(input int ackPct, input int donePct, input int badPct,
                            input int holdAck, input bit doneAfterIssue, input int dupId);
      int validRun, cycles, pick;
      bit a, d, dupSent, st;
      int q[$];
      validRun = 0; cycles = 0; dupSent = 0;
      applyStimulus(1, 0, 0, 0);
      while (mBusy && cycles < 3000) begin
         cycles++;
         st = ($urandom_range(0, 99) < 10);
         setLegalCfg($urandom_range(0, 64));
         a = 0;
         if (validRun >= holdAck) a = ($urandom_range(0, 99) < ackPct);
         else if (!mValid) a = ($urandom_range(0, 99) < 50);
         d = 0; pick = 0;
         if (dupId >= 0 && !dupSent && mSeen[dupId]) begin
            d = 1; pick = dupId; dupSent = 1;
         end else if ((!doneAfterIssue || mIssued == mNumWg) && $urandom_range(0, 99) < donePct) begin
            q.delete();
            for (int i = 0; i < mIssued; i++) if (!mSeen[i]) q.push_back(i);
            if (q.size() > 0) begin d = 1; pick = q[$urandom_range(0, q.size() - 1)]; end
         end else if ($urandom_range(0, 99) < badPct) begin
            d = 1; pick = $urandom_range(0, 63);
         end
         if (mValid && !a) validRun++;
         else validRun = 0;
         applyStimulus(st, a, d, pick);
      end
      if (mBusy) checkOutput("kernelTimeout", 1, 0);
      applyStimulus(0, 0, 0, 0);
   endtask

   initial begin
      modelReset();
      cfg_start = 0; ack = 0; wfDone = 0; wfDoneId = '0;
      setCfg(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      rst = 1'b1;
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, $urandom_range(0, 63));

      // Basic kernel: 3 WGs, totals 64 and 8, completions only after the last issue.
      setCfg(3, 4, 16, 2);
      runKernel(100, 100, 0, 0, 1, -1);
      checkOutput("basicIdle", busy, 0);

      // Backpressure: every WG is held 20 cycles before its ack.
      setCfg(4, 3, 20, 5);
      runKernel(100, 40, 0, 20, 0, -1);

      // Overflow and empty-kernel rejection.
      setCfg(3, 8, 10, 4);
      applyStimulus(1, 0, 0, 0);
      checkOutput("sgprOvfErr", kernel_err, 1);
      applyStimulus(0, 1, 1, 0);
      setCfg(3, 15, 40, 1);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      setCfg(0, 1, 1, 1);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);

      // Full 64-WG kernel, then again with a duplicate completion for WG 5.
      setLegalCfg(64);
      runKernel(70, 30, 0, 0, 0, -1);
      setLegalCfg(64);
      runKernel(70, 30, 0, 0, 0, 5);
      checkOutput("dupErrSticky", kernel_err, 1);

      // Immediate acks and immediate completions: WG 0 completes in the gap after its ack.
      setLegalCfg(4);
      runKernel(100, 100, 0, 0, 0, -1);

      // Randomized kernels with occasional bogus completions.
      for (int k = 0; k < 20; k++) begin
         setLegalCfg($urandom_range(1, 64));
         runKernel($urandom_range(20, 100), $urandom_range(10, 80), 5, 0, 0, -1);
      end

      // Asynchronous abort mid-kernel.
      setLegalCfg(10);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      #2 rst = 1'b0;
      #1 checkResetOutputs("abort");
      modelReset();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
